// File: rtl/id_stage.sv
// Decode stage: IF/ID pipeline register, 32-entry register file, early branch/jump resolve.
// Ports: clk/rst; fetch in (instr_f, pc_fetch_f); hazard in (stall_d, flush_d, fwd_a/b,
//   alu_result_m); writeback in (wb_we/addr/data); fetch redirect out (pcsrc, pc_branch,
//   jump, pc_jump, flush_req); ID/EX operands out (valid_d, rd1/rd2, imm_ext, fields, pc_plus4_d).
module id_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    instr_f,
    input  logic [WIDTH-1:0]    pc_fetch_f,
    input  logic                stall_d,
    input  logic                flush_d,
    input  logic                wb_we,
    input  logic [REG_ADDR-1:0] wb_addr,
    input  logic [WIDTH-1:0]    wb_data,
    input  logic                fwd_a,
    input  logic                fwd_b,
    input  logic [WIDTH-1:0]    alu_result_m,
    output logic                pcsrc,
    output logic [WIDTH-1:0]    pc_branch,
    output logic                jump,
    output logic [WIDTH-1:0]    pc_jump,
    output logic                flush_req,
    output logic                valid_d,
    output logic [WIDTH-1:0]    rd1,
    output logic [WIDTH-1:0]    rd2,
    output logic [WIDTH-1:0]    imm_ext,
    output logic [REG_ADDR-1:0] rs_d,
    output logic [REG_ADDR-1:0] rt_d,
    output logic [REG_ADDR-1:0] rd_d,
    output logic [5:0]          op_d,
    output logic [5:0]          funct_d,
    output logic [WIDTH-1:0]    pc_plus4_d
);

    localparam int NREG = 2 ** REG_ADDR;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc_plus4;
        logic             valid;
    } if_id_t;

    if_id_t           if_id;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] instr_d;
    logic [15:0]      imm16;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;

    // Flush outranks stall so a squashed slot never lingers.
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            if_id <= '0;
        end else if (!stall_d) begin
            if_id.instr    <= instr_f;
            if_id.pc_plus4 <= pc_fetch_f;
            if_id.valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign instr_d    = if_id.instr;
    assign valid_d    = if_id.valid;
    assign pc_plus4_d = if_id.pc_plus4;

    assign op_d    = instr_d[31:26];
    assign rs_d    = instr_d[25:21];
    assign rt_d    = instr_d[20:16];
    assign rd_d    = instr_d[15:11];
    assign funct_d = instr_d[5:0];
    assign imm16   = instr_d[15:0];

    // Write-through: a same-cycle writeback is visible to the reader.
    always_comb begin
        if (rs_d == '0) begin
            rd1 = '0;
        end else if (wb_we && wb_addr == rs_d) begin
            rd1 = wb_data;
        end else begin
            rd1 = regs[rs_d];
        end
    end

    always_comb begin
        if (rt_d == '0) begin
            rd2 = '0;
        end else if (wb_we && wb_addr == rt_d) begin
            rd2 = wb_data;
        end else begin
            rd2 = regs[rt_d];
        end
    end

    assign imm_sext = {{(WIDTH-16){imm16[15]}}, imm16};

    // Logical-immediate ops take a zero-extended immediate.
    always_comb begin
        imm_ext = imm_sext;
        unique case (op_d)
            6'h0C, 6'h0D, 6'h0E: imm_ext = {{(WIDTH-16){1'b0}}, imm16};
            default:             imm_ext = imm_sext;
        endcase
    end

    assign cmp_a = fwd_a ? alu_result_m : rd1;
    assign cmp_b = fwd_b ? alu_result_m : rd2;

    assign pc_branch = pc_plus4_d + {imm_sext[WIDTH-3:0], 2'b00};
    assign pc_jump   = {pc_plus4_d[WIDTH-1:WIDTH-4], instr_d[25:0], 2'b00};

    always_comb begin
        pcsrc = 1'b0;
        jump  = 1'b0;
        if (valid_d) begin
            unique case (1'b1)
                op_d == 6'h04: pcsrc = (cmp_a == cmp_b);
                op_d == 6'h05: pcsrc = (cmp_a != cmp_b);
                op_d == 6'h02: jump  = 1'b1;
                default: ;
            endcase
        end
    end

    assign flush_req = pcsrc | jump;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios plus random traffic
// compared every cycle against a behavioural decode model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_f, pc_fetch_f;
    logic        stall_d, flush_d;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fwd_a, fwd_b;
    logic [31:0] alu_result_m;
    logic        pcsrc, jump, flush_req, valid_d;
    logic [31:0] pc_branch, pc_jump, rd1, rd2, imm_ext, pc_plus4_d;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic [5:0]  op_d, funct_d;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_instr, m_pc;
    logic        m_valid;

    id_stage dut (
        .clk(clk), .rst(rst),
        .instr_f(instr_f), .pc_fetch_f(pc_fetch_f),
        .stall_d(stall_d), .flush_d(flush_d),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .alu_result_m(alu_result_m),
        .pcsrc(pcsrc), .pc_branch(pc_branch),
        .jump(jump), .pc_jump(pc_jump),
        .flush_req(flush_req), .valid_d(valid_d),
        .rd1(rd1), .rd2(rd2), .imm_ext(imm_ext),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .op_d(op_d), .funct_d(funct_d),
        .pc_plus4_d(pc_plus4_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'd0;
        if (wb_we && int'(wb_addr) == a) return wb_data;
        return m_regs[a];
    endfunction

    task automatic check_all();
        int op, rs, rt, rd, fn, imm16, simm;
        logic [31:0] e_rd1, e_rd2, e_imm, a, b;
        logic e_br, e_j;
        op    = int'(m_instr >> 26);
        rs    = int'((m_instr >> 21) & 32'd31);
        rt    = int'((m_instr >> 16) & 32'd31);
        rd    = int'((m_instr >> 11) & 32'd31);
        fn    = int'(m_instr & 32'd63);
        imm16 = int'(m_instr & 32'hFFFF);
        simm  = (imm16 >= 32768) ? imm16 - 65536 : imm16;
        e_rd1 = m_read(rs);
        e_rd2 = m_read(rt);
        if (op == 12 || op == 13 || op == 14) e_imm = 32'(imm16);
        else e_imm = 32'(simm);
        a    = fwd_a ? alu_result_m : e_rd1;
        b    = fwd_b ? alu_result_m : e_rd2;
        e_br = m_valid && ((op == 4 && a == b) || (op == 5 && a != b));
        e_j  = m_valid && op == 2;
        check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
        check("op_d", {26'd0, op_d}, 32'(op));
        check("rs_d", {27'd0, rs_d}, 32'(rs));
        check("rt_d", {27'd0, rt_d}, 32'(rt));
        check("rd_d", {27'd0, rd_d}, 32'(rd));
        check("funct_d", {26'd0, funct_d}, 32'(fn));
        check("pc_plus4_d", pc_plus4_d, m_pc);
        check("rd1", rd1, e_rd1);
        check("rd2", rd2, e_rd2);
        check("imm_ext", imm_ext, e_imm);
        check("pc_branch", pc_branch, m_pc + 32'(simm * 4));
        check("pcsrc", {31'd0, pcsrc}, {31'd0, e_br});
        check("jump", {31'd0, jump}, {31'd0, e_j});
        check("pc_jump", pc_jump,
              (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2));
        check("flush_req", {31'd0, flush_req}, {31'd0, e_br | e_j});
    endtask

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_instr = 0; m_pc = 0; m_valid = 0;
        end else begin
            if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
            if (flush_d) begin
                m_instr = 0; m_pc = 0; m_valid = 0;
            end else if (!stall_d) begin
                m_instr = instr_f; m_pc = pc_fetch_f; m_valid = 1;
            end
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
        instr_f = 0; pc_fetch_f = 0;
        wb_we = 1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 0;
    endtask

    initial begin
        int ops [8] = '{0, 2, 4, 5, 12, 13, 14, 35};
        int k;
        rst = 1; instr_f = 0; pc_fetch_f = 0;
        stall_d = 0; flush_d = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        fwd_a = 0; fwd_b = 0; alu_result_m = 0;
        m_instr = 'x; m_pc = 'x; m_valid = 'x;
        @(negedge clk);
        @(posedge clk);
        model_update();
        @(negedge clk);
        tick();
        tick();
        rst = 0;

        for (int i = 1; i < 32; i++) begin
            instr_f = (32'(i) << 21) | (32'((i % 31) + 1) << 16);
            tick();
            check("rst_reg_rd1", rd1, 32'd0);
        end

        set_reg(1, 5); set_reg(2, 5);
        instr_f = 32'h1022_0003; pc_fetch_f = 32'h10;
        tick();
        check("beq_pcsrc", {31'd0, pcsrc}, 32'd1);
        check("beq_target", pc_branch, 32'h1C);
        check("beq_flush_req", {31'd0, flush_req}, 32'd1);

        set_reg(1, 1); set_reg(2, 2);
        instr_f = 32'h1422_FFFF; pc_fetch_f = 32'h20;
        tick();
        check("bne_pcsrc", {31'd0, pcsrc}, 32'd1);
        check("bne_target", pc_branch, 32'h1C);
        set_reg(2, 1);
        instr_f = 32'h1422_FFFF; pc_fetch_f = 32'h20;
        tick();
        check("bne_eq_pcsrc", {31'd0, pcsrc}, 32'd0);

        instr_f = 32'h0800_0040; pc_fetch_f = 32'h8;
        tick();
        check("j_jump", {31'd0, jump}, 32'd1);
        check("j_target", pc_jump, 32'h100);
        check("j_flush_req", {31'd0, flush_req}, 32'd1);

        instr_f = 32'h8C43_0010; pc_fetch_f = 32'h40;
        tick();
        stall_d = 1;
        for (int i = 0; i < 3; i++) begin
            instr_f = $urandom; pc_fetch_f = $urandom;
            tick();
            check("stall_op", {26'd0, op_d}, 32'h23);
            check("stall_pc", pc_plus4_d, 32'h40);
        end
        flush_d = 1;
        tick();
        check("flush_valid", {31'd0, valid_d}, 32'd0);
        check("flush_op", {26'd0, op_d}, 32'd0);
        stall_d = 0; flush_d = 0;

        instr_f = 32'h0060_0000;
        tick();
        wb_we = 1; wb_addr = 3; wb_data = 32'hABCD;
        #1 check("wt_rd1", rd1, 32'hABCD);
        instr_f = 0;
        tick();
        wb_addr = 0; wb_data = 32'h1234;
        #1 check("r0_wt", rd1, 32'd0);
        tick();
        wb_we = 0;
        #1 check("r0_after", rd1, 32'd0);

        instr_f = 32'h1062_0004; pc_fetch_f = 32'h50;
        tick();
        fwd_a = 1; alu_result_m = 32'd1;
        #1 check("fwd_pcsrc", {31'd0, pcsrc}, 32'd1);
        fwd_a = 0;
        #1 check("nofwd_pcsrc", {31'd0, pcsrc}, 32'd0);
        instr_f = 0;
        tick();

        for (int n = 0; n < 400; n++) begin
            k = int'($urandom_range(0, 8));
            instr_f = (k == 8) ? $urandom
                    : (32'(ops[k]) << 26) | (32'($urandom_range(0, 7)) << 21)
                      | (32'($urandom_range(0, 7)) << 16) | ($urandom & 32'hFFFF);
            pc_fetch_f   = $urandom;
            stall_d      = ($urandom_range(0, 3) == 0);
            flush_d      = ($urandom_range(0, 9) == 0);
            rst          = ($urandom_range(0, 49) == 0);
            wb_we        = $urandom_range(0, 1) == 1;
            wb_addr      = 5'($urandom_range(0, 7));
            wb_data      = 32'($urandom_range(0, 3));
            fwd_a        = $urandom_range(0, 1) == 1;
            fwd_b        = $urandom_range(0, 1) == 1;
            alu_result_m = 32'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
